// File: rtl/fft_peak_detect_if.sv
// rtl/fft_peak_detect_if.sv - FFT unload stream bundle (framing strobes, bin index, amplitude)
interface fft_peak_detect_if #(
    parameter int IDX_W = 10,
    parameter int AMP_W = 17
);
    logic             fft_soud;
    logic             fft_opd;
    logic             fft_eoud;
    logic [IDX_W-1:0] fft_idx;
    logic [AMP_W-1:0] fft_amp;

    modport master (
        output fft_soud, fft_opd, fft_eoud, fft_idx, fft_amp
    );

    modport slave (
        input  fft_soud, fft_opd, fft_eoud, fft_idx, fft_amp
    );
endinterface

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - windowed top-2 peak and amplitude-sum detector on the FFT unload stream
module fft_peak_detect #(
    parameter int IDX_W  = 10,
    parameter int AMP_W  = 17,
    parameter int N_BINS = 1024,
    parameter int SUM_W  = 27
) (
    input  logic             clk,
    input  logic             rst,
    fft_peak_detect_if.slave up,
    input  logic [IDX_W-1:0] win_lo,
    input  logic [IDX_W-1:0] win_hi,
    input  logic [AMP_W-1:0] thresh,
    output logic             busy,
    output logic             res_valid,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_idx,
    output logic [AMP_W-1:0] peak_amp,
    output logic [IDX_W-1:0] peak2_idx,
    output logic [AMP_W-1:0] peak2_amp,
    output logic [SUM_W-1:0] amp_sum,
    output logic             frame_err
);
    localparam int CNT_W = $clog2(N_BINS + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BINS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    logic [1:0]       state;
    logic             abort_q;
    logic             err_q;

    logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
    logic [SUM_W-1:0] sum, sum_base, sum_nxt;
    logic             found, found_base, found_nxt;
    logic [IDX_W-1:0] b_idx, b_idx_base, b_idx_nxt;
    logic [AMP_W-1:0] b_amp, b_amp_base, b_amp_nxt;
    logic [IDX_W-1:0] s_idx, s_idx_base, s_idx_nxt;
    logic [AMP_W-1:0] s_amp, s_amp_base, s_amp_nxt;

    logic start, in_win, cand, load;

    assign start  = up.fft_soud & up.fft_opd;
    assign in_win = (up.fft_idx >= win_lo) && (up.fft_idx <= win_hi);
    assign cand   = in_win && (up.fft_amp >= thresh);
    assign load   = start | ((state == S_COLLECT) & up.fft_opd);

    // A start sample seeds from a cleared state instead of accumulating onto the old frame.
    always_comb begin
        if (start) begin
            cnt_base   = '0;
            sum_base   = '0;
            found_base = 1'b0;
            b_idx_base = '0;
            b_amp_base = '0;
            s_idx_base = '0;
            s_amp_base = '0;
        end else begin
            cnt_base   = cnt;
            sum_base   = sum;
            found_base = found;
            b_idx_base = b_idx;
            b_amp_base = b_amp;
            s_idx_base = s_idx;
            s_amp_base = s_amp;
        end

        cnt_nxt   = cnt_base;
        sum_nxt   = sum_base;
        found_nxt = found_base;
        b_idx_nxt = b_idx_base;
        b_amp_nxt = b_amp_base;
        s_idx_nxt = s_idx_base;
        s_amp_nxt = s_amp_base;

        if (up.fft_opd) begin
            cnt_nxt = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
            if (in_win) begin
                sum_nxt = sum_base + SUM_W'(up.fft_amp);
            end
            // Strict compares keep the earlier bin on equal amplitudes.
            if (cand) begin
                found_nxt = 1'b1;
                if (up.fft_amp > b_amp_base) begin
                    s_idx_nxt = b_idx_base;
                    s_amp_nxt = b_amp_base;
                    b_idx_nxt = up.fft_idx;
                    b_amp_nxt = up.fft_amp;
                end else if (up.fft_amp > s_amp_base) begin
                    s_idx_nxt = up.fft_idx;
                    s_amp_nxt = up.fft_amp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
            sum        <= '0;
            found      <= 1'b0;
            b_idx      <= '0;
            b_amp      <= '0;
            s_idx      <= '0;
            s_amp      <= '0;
            res_valid  <= 1'b0;
            peak_found <= 1'b0;
            peak_idx   <= '0;
            peak_amp   <= '0;
            peak2_idx  <= '0;
            peak2_amp  <= '0;
            amp_sum    <= '0;
        end else begin
            res_valid <= 1'b0;
            abort_q   <= 1'b0;

            if (load) begin
                cnt   <= cnt_nxt;
                sum   <= sum_nxt;
                found <= found_nxt;
                b_idx <= b_idx_nxt;
                b_amp <= b_amp_nxt;
                s_idx <= s_idx_nxt;
                s_amp <= s_amp_nxt;
            end

            case (state)
                S_IDLE: begin
                    if (start) state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (start) begin
                        abort_q <= 1'b1;
                    end else if (up.fft_eoud) begin
                        // Results come from the next-state view so a coincident last sample counts.
                        state      <= S_REPORT;
                        res_valid  <= 1'b1;
                        peak_found <= found_nxt;
                        peak_idx   <= b_idx_nxt;
                        peak_amp   <= b_amp_nxt;
                        peak2_idx  <= s_idx_nxt;
                        peak2_amp  <= s_amp_nxt;
                        amp_sum    <= sum_nxt;
                        err_q      <= (cnt_nxt != CNT_FULL);
                    end
                end
                S_REPORT: begin
                    state <= start ? S_COLLECT : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == S_COLLECT);
    assign frame_err = err_q | abort_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - randomized and directed checks of fft_peak_detect against a frame-level model
module tb_fft_peak_detect;
    localparam int IDX_W  = 10;
    localparam int AMP_W  = 17;
    localparam int N_BINS = 1024;
    localparam int SUM_W  = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_peak_detect_if #(.IDX_W(IDX_W), .AMP_W(AMP_W)) up ();

    logic [IDX_W-1:0] win_lo, win_hi;
    logic [AMP_W-1:0] thresh;
    logic             busy, res_valid, peak_found, frame_err;
    logic [IDX_W-1:0] peak_idx, peak2_idx;
    logic [AMP_W-1:0] peak_amp, peak2_amp;
    logic [SUM_W-1:0] amp_sum;

    fft_peak_detect #(.IDX_W(IDX_W), .AMP_W(AMP_W), .N_BINS(N_BINS), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .up(up),
        .win_lo(win_lo), .win_hi(win_hi), .thresh(thresh),
        .busy(busy), .res_valid(res_valid), .peak_found(peak_found),
        .peak_idx(peak_idx), .peak_amp(peak_amp),
        .peak2_idx(peak2_idx), .peak2_amp(peak2_amp),
        .amp_sum(amp_sum), .frame_err(frame_err)
    );

    typedef struct { int idx; int amp; } smp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 0;
    int   amps [N_BINS];
    smp_t frame_q [$];

    bit m_collect, e_rv, e_abort, e_found, e_err;
    int e_pidx, e_pamp, e_p2idx, e_p2amp, e_sum;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_collect = 0; e_rv = 0; e_abort = 0; e_found = 0; e_err = 0;
        e_pidx = 0; e_pamp = 0; e_p2idx = 0; e_p2amp = 0; e_sum = 0;
        frame_q.delete();
    endfunction

    // Whole-frame evaluation: top two by amplitude, earliest arrival wins ties, zero amplitude never ranks.
    function automatic void model_report();
        int  s = 0;
        bit  f = 0;
        int  bi = -1;
        int  si = -1;
        bit  c [$];
        foreach (frame_q[i]) begin
            bit w = (frame_q[i].idx >= int'(win_lo)) && (frame_q[i].idx <= int'(win_hi));
            if (w) s += frame_q[i].amp;
            c.push_back(w && (frame_q[i].amp >= int'(thresh)));
            if (c[i]) f = 1;
        end
        foreach (frame_q[i])
            if (c[i] && frame_q[i].amp > 0 && (bi < 0 || frame_q[i].amp > frame_q[bi].amp)) bi = i;
        foreach (frame_q[i])
            if (i != bi && c[i] && frame_q[i].amp > 0 && (si < 0 || frame_q[i].amp > frame_q[si].amp)) si = i;
        e_rv    = 1;
        e_found = f;
        e_sum   = s;
        e_pidx  = (bi < 0) ? 0 : frame_q[bi].idx;
        e_pamp  = (bi < 0) ? 0 : frame_q[bi].amp;
        e_p2idx = (si < 0) ? 0 : frame_q[si].idx;
        e_p2amp = (si < 0) ? 0 : frame_q[si].amp;
        e_err   = (frame_q.size() != N_BINS);
    endfunction

    function automatic void model_step(bit soud, bit opd, bit eoud, int idx, int amp);
        smp_t sm;
        bit   st = soud && opd;
        sm.idx = idx;
        sm.amp = amp;
        e_rv = 0;
        e_abort = 0;
        if (m_collect) begin
            if (st) begin
                e_abort = 1;
                frame_q.delete();
                frame_q.push_back(sm);
            end else begin
                if (opd) frame_q.push_back(sm);
                if (eoud) begin
                    model_report();
                    m_collect = 0;
                end
            end
        end else if (st) begin
            m_collect = 1;
            frame_q.delete();
            frame_q.push_back(sm);
        end
    endfunction

    task automatic drive(bit soud, bit opd, bit eoud, int idx, int amp);
        up.fft_soud = soud;
        up.fft_opd  = opd;
        up.fft_eoud = eoud;
        up.fft_idx  = IDX_W'(idx);
        up.fft_amp  = AMP_W'(amp);
        @(posedge clk);
        model_step(soud, opd, eoud, idx & 32'h3ff, amp & 32'h1ffff);
        #1;
    endtask

    // Idle cycles also carry stray soud-without-opd and eoud-in-idle, both of which must be ignored.
    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 1)), 1'b0, i == 0, $urandom, $urandom);
    endtask

    // eoud_mode: 0 none, 1 with last sample, 2 on a separate cycle
    task automatic frame(int n, bit gaps, int eoud_mode);
        for (int i = 0; i < n; i++) begin
            if (gaps && i != 0 && $urandom_range(0, 3) == 0)
                drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom);
            drive(i == 0, 1'b1, (eoud_mode == 1) && (i == n - 1), i % N_BINS, amps[i % N_BINS]);
        end
        if (eoud_mode == 2) drive(1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_collect);
            chk("res_valid", res_valid, e_rv);
            chk("frame_err", frame_err, e_err | e_abort);
            chk("peak_found", peak_found, e_found);
            chk("peak_idx", peak_idx, e_pidx);
            chk("peak_amp", peak_amp, e_pamp);
            chk("peak2_idx", peak2_idx, e_p2idx);
            chk("peak2_amp", peak2_amp, e_p2amp);
            chk("amp_sum", amp_sum, e_sum);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        up.fft_soud = 0; up.fft_opd = 0; up.fft_eoud = 0; up.fft_idx = '0; up.fft_amp = '0;
        win_lo = 10'd1; win_hi = 10'd511; thresh = '0;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1;
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_peak_idx", peak_idx, 0);
        chk("reset_amp_sum", amp_sum, 0);
        idle(2);

        // Ramp frame with two planted peaks
        foreach (amps[i]) amps[i] = i;
        amps[100] = 5000;
        amps[300] = 4000;
        frame(N_BINS, 0, 1);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_peak_idx", peak_idx, 100);
        chk("t1_peak_amp", peak_amp, 5000);
        chk("t1_peak2_idx", peak2_idx, 300);
        chk("t1_peak2_amp", peak2_amp, 4000);
        chk("t1_found", peak_found, 1);
        chk("t1_err", frame_err, 0);
        chk("t1_sum", amp_sum, 139416);
        idle(3);

        thresh = 17'd6000;
        frame(N_BINS, 1, 1);
        chk("t2_found", peak_found, 0);
        chk("t2_peak_amp", peak_amp, 0);
        chk("t2_peak2_idx", peak2_idx, 0);
        chk("t2_sum", amp_sum, 139416);
        idle(2);

        // Equal peaks: earlier bin wins
        win_lo = 10'd0; win_hi = 10'd1023; thresh = '0;
        foreach (amps[i]) amps[i] = 0;
        amps[50] = 7000;
        amps[60] = 7000;
        frame(N_BINS, 1, 2);
        chk("t3_peak_idx", peak_idx, 50);
        chk("t3_peak2_idx", peak2_idx, 60);
        chk("t3_peak2_amp", peak2_amp, 7000);
        idle(2);

        // Truncated frame
        win_lo = 10'd1; win_hi = 10'd511;
        foreach (amps[i]) amps[i] = i;
        amps[100] = 5000;
        amps[300] = 4000;
        frame(1000, 0, 2);
        chk("t4_res_valid", res_valid, 1);
        chk("t4_err", frame_err, 1);
        chk("t4_peak_idx", peak_idx, 100);
        chk("t4_sum", amp_sum, 139416);
        idle(2);

        // Abort after 200 samples, then a clean frame
        win_lo = 10'd0; win_hi = 10'd1023;
        foreach (amps[i]) amps[i] = i % 64;
        amps[20] = 900;
        frame(200, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, amps[0]);
        chk("t5_abort_err", frame_err, 1);
        chk("t5_abort_no_rv", res_valid, 0);
        for (int i = 1; i < N_BINS; i++) drive(1'b0, 1'b1, i == N_BINS - 1, i, amps[i]);
        chk("t5_peak_idx", peak_idx, 20);
        chk("t5_peak_amp", peak_amp, 900);
        chk("t5_err", frame_err, 0);
        idle(2);

        // Reset mid-frame
        frame(300, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_peak_amp", peak_amp, 0);
        chk("t6_rst_sum", amp_sum, 0);
        chk("t6_rst_found", peak_found, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        frame(N_BINS, 0, 1);
        chk("t6_peak_idx", peak_idx, 20);
        chk("t6_peak_amp", peak_amp, 900);

        // Back-to-back frames: second start lands in the report cycle
        frame(N_BINS, 0, 1);
        frame(N_BINS, 1, 1);
        idle(2);

        for (int f = 0; f < 16; f++) begin
            int mode, len;
            win_lo = IDX_W'($urandom);
            win_hi = ($urandom_range(0, 4) == 0) ? IDX_W'($urandom) : IDX_W'($urandom_range(int'(win_lo), 1023));
            thresh = AMP_W'($urandom_range(0, 400));
            foreach (amps[i])
                amps[i] = ($urandom_range(0, 30) == 0) ? $urandom_range(0, 131071) : $urandom_range(0, 500);
            mode = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 2);
            len  = $urandom_range(0, 2) == 0 ? $urandom_range(1, 1100) : N_BINS;
            frame(len, 1'($urandom_range(0, 1)), mode);
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
Streaming spectrum peak detector directly downstream of the FFT core. Consumes the per-bin unload stream (index, 17-bit amplitude, data_soud/data_opd/data_eoud framing) and tracks the largest and second-largest bins inside a programmable search window. It also accumulates total in-window amplitude. One registered result set is published per FFT frame for the control/display logic.

Parameters:
IDX_W, 10, bin index width
AMP_W, 17, amplitude width; matches FFT amp output
N_BINS, 1024, expected samples per frame
SUM_W, 27, accumulator width (AMP_W+IDX_W, cannot overflow for N_BINS samples)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
fft_soud  in  1  first-sample strobe of FFT unload
fft_opd  in  1  output sample valid
fft_eoud  in  1  unload complete strobe
fft_idx  in  IDX_W  bin index of current sample
fft_amp  in  AMP_W  bin amplitude of current sample
win_lo  in  IDX_W  search window low bin, inclusive
win_hi  in  IDX_W  search window high bin, inclusive
thresh  in  AMP_W  minimum amplitude for peak candidacy
busy  out  1  frame being collected
res_valid  out  1  one-cycle pulse: result registers updated
peak_found  out  1  at least one in-window bin reached thresh
peak_idx  out  IDX_W  bin of largest amplitude
peak_amp  out  AMP_W  largest amplitude
peak2_idx  out  IDX_W  bin of second-largest amplitude
peak2_amp  out  AMP_W  second-largest amplitude
amp_sum  out  SUM_W  sum of all in-window amplitudes
frame_err  out  1  frame malformed (see below)

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM IDLE; internal best/second/sum/count cleared.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE -> COLLECT when fft_soud & fft_opd; that sample is processed as the first sample (best/second/sum/count seeded from it, not accumulated onto stale values).
- Samples with fft_opd=0 are ignored in every state; fft_soud without fft_opd is ignored.
- Per valid sample in COLLECT: count+1. If win_lo<=fft_idx<=win_hi:
  - amp_sum += fft_amp.
  - If fft_amp>=thresh: if fft_amp > best, then second<=best, best<=sample; else if fft_amp > second, then second<=sample.
- Comparisons are strict, so on ties the earlier (lower-arrival) bin is kept.
- win_lo>win_hi means an empty window: no samples qualify, sum stays 0.
- win_lo, win_hi and thresh are sampled every cycle; they must be held stable during a frame. Behaviour under mid-frame changes is undefined.
- COLLECT -> REPORT on fft_eoud. If fft_opd is high in the same cycle, that sample is processed first.
- REPORT (exactly 1 cycle):
  - Result registers load and res_valid=1; return to IDLE.
  - Latency: res_valid is high the cycle after the fft_eoud cycle.
- Result content:
  - peak_found=1 iff at least one candidate was seen.
  - If no candidate: peak_idx/peak_amp=0. If only one candidate: peak2_idx/peak2_amp=0.
  - frame_err=1 iff count != N_BINS; results are still reported.
- fft_soud&fft_opd while in COLLECT:
  - Current frame is aborted with no res_valid.
  - frame_err pulses 1 for one cycle.
  - A new frame is seeded from that sample; the FSM stays in COLLECT.
- fft_soud&fft_opd in the REPORT cycle: the report completes and the new frame is seeded in the same cycle (FSM -> COLLECT).
- fft_eoud in IDLE is ignored.
- Result outputs hold until the next res_valid. frame_err is held with results, except for an abort pulse.
- busy=1 in COLLECT, 0 otherwise.
- Reset asserted mid-frame: everything clears immediately; no res_valid is produced.

Test Plan:
- Reset released, window 1..511, thresh 0. Frame of 1024 samples: amp=idx except bin 100=5000 and bin 300=4000. -> res_valid one cycle after eoud; peak 100/5000, peak2 300/4000, peak_found=1, frame_err=0, amp_sum = sum(1..511) - 100 - 300 + 9000 = 139,416.
- Same frame with thresh=6000. -> peak_found=0, all peak fields 0, amp_sum unchanged at 139,416.
- Bins 50 and 60 both 7000, all other bins 0, window 0..1023. -> peak_idx=50, peak2_idx=60, peak2_amp=7000.
- Frame truncated to 1000 samples before eoud. -> res_valid=1 with frame_err=1 and results computed over those 1000 samples.
- Second soud after 200 samples, then a full 1024-sample frame with a peak at bin 20=900. -> frame_err pulse at the restart and no res_valid for the aborted frame. Next res_valid reports peak 20/900, frame_err=0.
- rst driven low mid-frame, then a clean frame. -> outputs 0 immediately; only the clean frame's res_valid appears, with correct values. Also: eoud coincident with the last opd -> that last sample is included.
